mips_16_imem_loader: RTL



---
 rtl/mips_16_imem_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mips_16_imem_loader.sv
// Boot loader: byte stream -> 16-bit instruction words written from address 0; holds the core in reset until the image is in.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module mips_16_imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_wr_en,
  output logic [ADDR_WIDTH-1:0] imem_wr_addr,
  output logic [15:0]           imem_wr_data,
  output logic                  core_rst,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef LOADER_CHECKSUM_EN
    S_CKSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t LP_END = S_CKSUM;
`else
  localparam state_t LP_END = S_DONE;
`endif

  localparam logic [16:0] LP_CAP = 17'(1) << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_len_hi;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_idx;
  logic [7:0]            r_hi;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [15:0]           r_wr_data;
  logic                  r_core_rst;
  logic                  r_done;
  logic                  r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_sum;
`endif

  logic                  w_ready;
  logic                  w_accept;
  logic [16:0]           w_len;
  logic [ADDR_WIDTH:0]   w_idx_next;

  assign w_len      = {1'b0, r_len_hi, rx_data};
  assign w_idx_next = r_idx + 1'b1;
  assign w_accept   = rx_valid && w_ready;

  always_comb begin
    w_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: w_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        S_CKSUM:                                  w_ready = 1'b1;
`endif
        default:                                  w_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      case (r_state)
        S_LEN_HI:  w_next = S_LEN_LO;
        S_LEN_LO: begin
          if (w_len > LP_CAP)     w_next = S_ERR;
          else if (w_len == '0)   w_next = LP_END;
          else                    w_next = S_DATA_HI;
        end
        S_DATA_HI: w_next = S_DATA_LO;
        S_DATA_LO: w_next = (w_idx_next < r_len) ? S_DATA_HI : LP_END;
`ifdef LOADER_CHECKSUM_EN
        S_CKSUM:   w_next = (rx_data == r_sum) ? S_DONE : S_ERR;
`endif
        default:   w_next = r_state;
      endcase
    end
  end

  // Status flags are registered from the next state so they change on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_LEN_HI;
      r_len_hi   <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_hi       <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_state    <= w_next;
      r_wr_en    <= 1'b0;
      r_core_rst <= (w_next != S_DONE);
      r_done     <= (w_next == S_DONE);
      r_err      <= (w_next == S_ERR);
      if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
        if (r_state != S_CKSUM) r_sum <= r_sum + rx_data;
`endif
        case (r_state)
          S_LEN_HI:  r_len_hi <= rx_data;
          S_LEN_LO:  r_len    <= w_len[ADDR_WIDTH:0];
          S_DATA_HI: r_hi     <= rx_data;
          S_DATA_LO: begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_idx[ADDR_WIDTH-1:0];
            r_wr_data <= {r_hi, rx_data};
            r_idx     <= w_idx_next;
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ready     = w_ready;
  assign imem_wr_en   = r_wr_en;
  assign imem_wr_addr = r_wr_addr;
  assign imem_wr_data = r_wr_data;
  assign core_rst     = r_core_rst;
  assign load_done    = r_done;
  assign load_error   = r_err;
  assign words_loaded = r_idx;

endmodule
